shift_exec_stage: RTL and testbench
===================================

Name: shift_exec_stage

Overview:
- Execute-stage shift unit that conditions operands for the 32-bit barrel left shifter and consumes its result.
- Supports SLL, SRL and SRA by bit-reversing around the left shifter.
- Two-stage valid/ready pipeline between decode/regfile read and the X/M latch.
- Carries a destination-register tag alongside each result; flush kills in-flight ops.

Parameters:
- TAG_WIDTH, 5, width of destination-register tag carried with each op.

Ports:
- clock input 1: single clock, all state rising-edge.
- reset_n input 1: reset, asynchronous assert, active-low.
- in_valid input 1: upstream presents an op.
- in_ready output 1: stage 1 can accept this cycle.
- in_operand input 32: value to shift.
- in_shamt input 5: shift amount 0..31.
- in_op input 2: 00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- in_tag input TAG_WIDTH: destination register.
- flush input 1: kill all in-flight ops.
- out_valid output 1: result available.
- out_ready input 1: downstream accepts.
- out_result output 32: shifted value.
- out_tag output TAG_WIDTH: tag of out_result.

Behaviour:
- Reset (reset_n low, async): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, all stage data regs 0. Deassertion takes effect at the next clock edge.
- Stage 1 register: holds operand, shamt, op, tag, s1_valid.
- Stage 2 register: holds result, tag, s2_valid; drives out_* directly.
- Handshakes:
  - s2_advance = !s2_valid || out_ready.
  - s1_advance = s2_advance.
  - in_ready = !s1_valid || s1_advance. Combinational, no dependency on in_valid.
- Transfers:
  - Input accepted when in_valid && in_ready; stage 1 loads and s1_valid=1.
  - If in_ready && !in_valid, s1_valid=0.
  - When s1_advance, stage 2 loads the stage-1 computed result/tag and s2_valid<=s1_valid.
  - When !s2_advance, both stages hold all contents.
- Latency and throughput: 2 cycles from accept to out_valid when not stalled; throughput 1 op/cycle.
- Datapath (combinational, between stage 1 and stage 2), with rev() = 32-bit bit reversal:
  - SLL: shifted = barrel_left(operand, shamt).
  - SRL: shifted = rev(barrel_left(rev(operand), shamt)).
  - SRA: SRL value OR fill, where fill = operand[31] ? ~rev(barrel_left(32'hFFFF_FFFF, shamt)) : 0.
  - shamt=0: result equals operand for all ops; fill = 0.
  - shamt=31: SRA of a negative value = 32'hFFFF_FFFF; SRL of 32'h8000_0000 = 1.
- Flush (synchronous, highest priority):
  - s1_valid<=0 and s2_valid<=0 next edge, regardless of out_ready.
  - An in_valid arriving in the flush cycle is dropped; in_ready still reports normally.
- Stall with output held: out_result/out_tag stable while out_valid && !out_ready.
- Simultaneous events:
  - Stage 2 draining (out_ready) while stage 1 full and new input: all three move in the same edge; no bubble.
  - Flush wins over any simultaneous accept.
- Reset mid-operation: all valid bits clear immediately (async); no partial result emitted.
- No combinational path from in_* to out_*; out_ready → in_ready is combinational, max 2 gate levels.

Decomposition:
- Shared package/header holds:
  - Op encodings SHIFT_OP_SLL=2'b00, SHIFT_OP_SRL=2'b01, SHIFT_OP_SRA=2'b10.
  - DATA_WIDTH=32, SHAMT_WIDTH=5.
- Sub-module shift_operand_conditioner:
  - Purely combinational; op + operand + shamt → result.
  - Instantiates the existing 32-bit barrel left shifter twice (data path, fill-mask path).
  - Implements both bit reversals.
- Top-level shift_exec_stage holds only the pipeline registers, handshake and flush logic.

Test Plan:
- Basic ops:
  - SLL 32'h0000_0001 by 31 → 32'h8000_0000.
  - SRL 32'h8000_0000 by 31 → 32'h0000_0001.
  - SRA 32'h8000_0000 by 4 → 32'hF800_0000.
  - SRA 32'h7000_0000 by 4 → 32'h0700_0000.
  - Each with tag echoed, out_valid exactly 2 cycles after accept.
- Back-to-back stream: 8 ops, in_valid=1, out_ready=1 → 8 consecutive out_valid cycles, order and tags preserved, in_ready never drops.
- Backpressure:
  - out_ready=0 for 5 cycles with 3 ops offered → exactly 2 accepted, in_ready=0 afterwards.
  - out_result stable throughout.
  - On out_ready=1, ops drain in order, third accepted same cycle.
- Flush with both stages full and out_ready=0 → next cycle out_valid=0; the op offered in the flush cycle never appears at the output.
- Boundaries:
  - shamt=0 on each op with 32'hDEAD_BEEF → 32'hDEAD_BEEF.
  - op=11 by 4 → 32'hEADB_EEF0.
- Async reset asserted mid-cycle with both stages full → out_valid=0 and out_result=0 before the next clock edge; first op after release has 2-cycle latency.

Source files
------------

// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the execute-stage shift unit: op encodings, widths,
// the stage-1 payload layout and the bit-reversal helper.
package shift_exec_stage_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;

  typedef enum logic [1:0] {
    SHIFT_OP_SLL  = 2'b00,
    SHIFT_OP_SRL  = 2'b01,
    SHIFT_OP_SRA  = 2'b10,
    SHIFT_OP_RSVD = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  operand;
    logic [SHAMT_WIDTH-1:0] shamt;
    shift_op_e              op;
  } s1_payload_t;

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      r[i] = v[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Upstream (decode/regfile) and downstream (X/M latch) valid/ready bundle.
interface shift_exec_stage_if #(
  parameter int unsigned TAG_WIDTH = 5
);
  import shift_exec_stage_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_operand;
  logic [SHAMT_WIDTH-1:0] in_shamt;
  logic [1:0]             in_op;
  logic [TAG_WIDTH-1:0]   in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_result;
  logic [TAG_WIDTH-1:0]   out_tag;

  modport slave (
    input  in_valid, in_operand, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

  modport master (
    output in_valid, in_operand, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/shift_exec_stage_barrel.sv
// 32-bit logarithmic barrel left shifter (zero fill), one mux rank per shamt bit.
module barrel_shift_left32
  import shift_exec_stage_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]  data_o
);

  logic [DATA_WIDTH-1:0] stage;

  always_comb begin
    stage = data_i;
    for (int unsigned i = 0; i < SHAMT_WIDTH; i++) begin
      if (shamt_i[i]) begin
        stage = stage << (1 << i);
      end
    end
    data_o = stage;
  end

endmodule

// File: rtl/shift_exec_stage_conditioner.sv
// Builds SLL/SRL/SRA from the left-only barrel shifter by reversing bits around
// it; a second shifter instance generates the sign-fill mask for SRA.
module shift_operand_conditioner
  import shift_exec_stage_pkg::*;
(
  input  shift_op_e              op_i,
  input  logic [DATA_WIDTH-1:0]  operand_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]  result_o
);

  logic                  right_shift;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_shl;
  logic [DATA_WIDTH-1:0] mask_shl;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] fill;

  assign right_shift = (op_i == SHIFT_OP_SRL) || (op_i == SHIFT_OP_SRA);
  assign data_in     = right_shift ? bit_rev(operand_i) : operand_i;

  barrel_shift_left32 u_data_shl (
    .data_i  (data_in),
    .shamt_i (shamt_i),
    .data_o  (data_shl)
  );

  barrel_shift_left32 u_mask_shl (
    .data_i  ('1),
    .shamt_i (shamt_i),
    .data_o  (mask_shl)
  );

  // Reversed-and-inverted mask marks exactly the top shamt bits vacated by SRL.
  always_comb begin
    shifted = right_shift ? bit_rev(data_shl) : data_shl;
    fill    = '0;
    if ((op_i == SHIFT_OP_SRA) && operand_i[DATA_WIDTH-1]) begin
      fill = ~bit_rev(mask_shl);
    end
    result_o = shifted | fill;
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready execute shift stage: operand latch, shift, result latch.
// Flush clears both valid bits and drops any op offered in the same cycle.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  shift_exec_stage_if.slave    bus
);

  s1_payload_t           s1_pay_q,    s1_pay_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q,    s1_tag_d;
  logic                  s1_valid_q,  s1_valid_d;
  logic [DATA_WIDTH-1:0] s2_result_q, s2_result_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q,    s2_tag_d;
  logic                  s2_valid_q,  s2_valid_d;

  logic                  s2_advance;
  logic                  s1_advance;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] s1_result;

  shift_operand_conditioner u_cond (
    .op_i      (s1_pay_q.op),
    .operand_i (s1_pay_q.operand),
    .shamt_i   (s1_pay_q.shamt),
    .result_o  (s1_result)
  );

  assign s2_advance = !s2_valid_q || bus.out_ready;
  assign s1_advance = s2_advance;
  assign in_ready   = !s1_valid_q || s1_advance;

  always_comb begin
    s1_pay_d    = s1_pay_q;
    s1_tag_d    = s1_tag_q;
    s1_valid_d  = s1_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
    s2_valid_d  = s2_valid_q;

    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_pay_d.operand = bus.in_operand;
        s1_pay_d.shamt   = bus.in_shamt;
        s1_pay_d.op      = shift_op_e'(bus.in_op);
        s1_tag_d         = bus.in_tag;
      end
    end

    if (s1_advance) begin
      s2_result_d = s1_result;
      s2_tag_d    = s1_tag_q;
      s2_valid_d  = s1_valid_q;
    end

    // Flush only kills valid bits; data regs follow their normal enables.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_pay_q    <= '0;
      s1_tag_q    <= '0;
      s1_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
    end else begin
      s1_pay_q    <= s1_pay_d;
      s1_tag_q    <= s1_tag_d;
      s1_valid_q  <= s1_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
      s2_valid_q  <= s2_valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_result_q;
  assign bus.out_tag    = s2_tag_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed cases plus a randomized
// stream scored against a plain-arithmetic shift model.
module tb_shift_exec_stage;

  localparam int unsigned TW = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  shift_exec_stage_if #(.TAG_WIDTH(TW)) bus ();

  shift_exec_stage #(.TAG_WIDTH(TW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] sh);
    case (op)
      2'b01:   return a >> sh;
      2'b10:   return 32'($signed(a) >>> sh);
      default: return a << sh;
    endcase
  endfunction

  typedef struct {
    logic [31:0]   result;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          sb_e;
  logic          held_q = 1'b0;
  logic [31:0]   held_res;
  logic [TW-1:0] held_tag;

  // Scoreboard: transfers are decided by the values visible before the edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (held_q) begin
        check_eq("hold_result", bus.out_result, held_res);
        check_eq("hold_tag", 32'(bus.out_tag), 32'(held_tag));
      end
      held_q   = bus.out_valid && !bus.out_ready && !flush;
      held_res = bus.out_result;
      held_tag = bus.out_tag;
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check_eq("sb_result", bus.out_result, sb_e.result);
          check_eq("sb_tag", 32'(bus.out_tag), 32'(sb_e.tag));
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        sb_e.result = ref_shift(bus.in_op, bus.in_operand, bus.in_shamt);
        sb_e.tag    = bus.in_tag;
        sb_q.push_back(sb_e);
      end
    end
  end

  always @(negedge reset_n) begin
    sb_q.delete();
    held_q = 1'b0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                       input logic [TW-1:0] tg);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_operand = a;
    bus.in_shamt   = sh;
    bus.in_tag     = tg;
  endtask

  // Expects an empty pipeline; leaves it empty.
  task automatic run_single(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [4:0] sh, input logic [TW-1:0] tg,
                            input logic [31:0] exp);
    bus.out_ready = 1'b1;
    drive(op, a, sh, tg);
    #1;
    check_eq({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({name, "_valid_c0"}, 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    #1;
    check_eq({name, "_valid_c1"}, 32'(bus.out_valid), 32'd0);
    step();
    check_eq({name, "_valid_c2"}, 32'(bus.out_valid), 32'd1);
    check_eq({name, "_result"}, bus.out_result, exp);
    check_eq({name, "_tag"}, 32'(bus.out_tag), 32'(tg));
    step();
    check_eq({name, "_valid_c3"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_a;
    bus.in_valid   = 1'b0;
    bus.in_operand = '0;
    bus.in_shamt   = '0;
    bus.in_op      = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b0;

    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_result", bus.out_result, 32'd0);
    check_eq("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    run_single("sll31", 2'b00, 32'h0000_0001, 5'd31, 5'd1, 32'h8000_0000);
    run_single("srl31", 2'b01, 32'h8000_0000, 5'd31, 5'd2, 32'h0000_0001);
    run_single("sra_neg4", 2'b10, 32'h8000_0000, 5'd4, 5'd3, 32'hF800_0000);
    run_single("sra_pos4", 2'b10, 32'h7000_0000, 5'd4, 5'd4, 32'h0700_0000);
    run_single("sra_neg31", 2'b10, 32'h8000_0001, 5'd31, 5'd5, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      run_single("shamt0", 2'(i), 32'hDEAD_BEEF, 5'd0, 5'(6 + i), 32'hDEAD_BEEF);
    end
    run_single("op11", 2'b11, 32'hDEAD_BEEF, 5'd4, 5'd10, 32'hEADB_EEF0);

    // Back-to-back stream of 8 ops
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 5'(8 + i));
      else bus.in_valid = 1'b0;
      #1;
      if (i < 8) check_eq("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      if (i >= 2) begin
        check_eq("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("b2b_out_tag", 32'(bus.out_tag), 32'(8 + i - 2));
      end
      step();
    end
    check_eq("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: three offered, two taken, third on release
    bus.out_ready = 1'b0;
    exp_a = ref_shift(2'b01, 32'hF0F0_1234, 5'd7);
    drive(2'b01, 32'hF0F0_1234, 5'd7, 5'd20);
    #1 check_eq("bp_in_ready_a", 32'(bus.in_ready), 32'd1);
    step();
    drive(2'b10, 32'h8123_4567, 5'd9, 5'd21);
    #1 check_eq("bp_in_ready_b", 32'(bus.in_ready), 32'd1);
    step();
    drive(2'b00, 32'h0000_00FF, 5'd12, 5'd22);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready_c", 32'(bus.in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_out_tag", 32'(bus.out_tag), 32'd20);
      check_eq("bp_out_result", bus.out_result, exp_a);
      step();
    end
    bus.out_ready = 1'b1;
    #1 check_eq("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    #1 check_eq("bp_drain_tag_b", 32'(bus.out_tag), 32'd21);
    check_eq("bp_drain_valid_b", 32'(bus.out_valid), 32'd1);
    step();
    check_eq("bp_drain_tag_c", 32'(bus.out_tag), 32'd22);
    check_eq("bp_drain_valid_c", 32'(bus.out_valid), 32'd1);
    step();
    check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

    // Flush with both stages full and output stalled
    bus.out_ready = 1'b0;
    drive(2'b00, 32'h1111_1111, 5'd1, 5'd23);
    step();
    drive(2'b00, 32'h2222_2222, 5'd2, 5'd24);
    step();
    drive(2'b00, 32'h3333_3333, 5'd3, 5'd25);
    flush = 1'b1;
    #1 check_eq("flush_full_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_full_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush_full_stays_empty", 32'(bus.out_valid), 32'd0);
    end

    // Flush while stage 1 is free: the offered op must still be dropped
    bus.out_ready = 1'b0;
    drive(2'b01, 32'h4444_4444, 5'd4, 5'd26);
    step();
    bus.in_valid = 1'b0;
    step();
    drive(2'b01, 32'h5555_5555, 5'd5, 5'd27);
    flush = 1'b1;
    #1 check_eq("flush_free_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_free_dropped", 32'(bus.out_valid), 32'd0);
      step();
    end

    // Asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    drive(2'b00, 32'h0F0F_0F0F, 5'd3, 5'd28);
    step();
    drive(2'b00, 32'h00F0_00F0, 5'd5, 5'd29);
    step();
    bus.in_valid = 1'b0;
    check_eq("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_out_result", bus.out_result, 32'd0);
    check_eq("arst_out_tag", 32'(bus.out_tag), 32'd0);
    #3 reset_n = 1'b1;
    step();
    run_single("post_rst", 2'b10, 32'hC000_0000, 5'd2, 5'd30, 32'hF000_0000);

    // Randomized stream with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_op      = 2'($urandom_range(0, 3));
      bus.in_operand = $urandom;
      bus.in_shamt   = 5'($urandom_range(0, 31));
      bus.in_tag     = 5'($urandom_range(0, 31));
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    check_eq("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
